// File: rtl/bypass_pkg.sv
// rtl/bypass_pkg.sv - shared tracker entry type and select encoding for the bypass unit
package bypass_pkg;

    localparam int RD_MAX_W   = 8;
    localparam int FWD_SEL_RF = 0;

    // rd is stored zero-extended so one entry type serves any REG_NUM up to 256
    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                is_load;
    } bypass_entry_t;

    function automatic int stage_to_sel(input int stage);
        return stage + 1;
    endfunction

endpackage

// File: rtl/bypass_select.sv
// rtl/bypass_select.sv - per-port youngest-producer match, ready check and operand select
module bypass_select
    import bypass_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter int RW         = 5,
    parameter int SEL_W      = 2
) (
    input  bypass_entry_t [DEPTH-1:0]       entries,
    input  logic [DEPTH*DATA_WIDTH-1:0]     stage_data,
    input  logic [RW-1:0]                   rs,
    input  logic                            rs_used,
    input  logic [DATA_WIDTH-1:0]           rf_data,
    output logic [DATA_WIDTH-1:0]           fwd_data,
    output logic [SEL_W-1:0]                fwd_sel,
    output logic                            stall
);

    // Scan oldest to youngest so the youngest match overwrites any older one
    always_comb begin
        fwd_data = rf_data;
        fwd_sel  = SEL_W'(FWD_SEL_RF);
        stall    = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rs_used && (rs != '0) && entries[k].valid && (entries[k].rd == RD_MAX_W'(rs))) begin
                if (!entries[k].is_load || (k >= LOAD_READY)) begin
                    fwd_sel  = SEL_W'(stage_to_sel(k));
                    fwd_data = stage_data[k*DATA_WIDTH +: DATA_WIDTH];
                    stall    = 1'b0;
                end else begin
                    fwd_sel  = SEL_W'(FWD_SEL_RF);
                    fwd_data = rf_data;
                    stall    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bypass_unit.sv
// rtl/bypass_unit.sv - forwarding/hazard unit; BYPASS_STATS_EN adds stall_count/fwd_count
module bypass_unit
    import bypass_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int REG_NUM      = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int DEPTH        = 3,
    parameter int LOAD_READY   = 1,
    localparam int RW          = $clog2(REG_NUM),
    localparam int SEL_W       = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               advance,
    input  logic                               flush,
    input  logic                               issue_valid,
    input  logic [RW-1:0]                      issue_rd,
    input  logic                               issue_is_load,
    input  logic [DEPTH*DATA_WIDTH-1:0]        stage_data,
    input  logic [NUM_RD_PORTS*RW-1:0]         rs,
    input  logic [NUM_RD_PORTS-1:0]            rs_used,
    input  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rf_data,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] fwd_data,
    output logic [NUM_RD_PORTS*SEL_W-1:0]      fwd_sel,
    output logic                               hazard_stall
`ifdef BYPASS_STATS_EN
    ,
    output logic [31:0]                        stall_count,
    output logic [31:0]                        fwd_count
`endif
);

    bypass_entry_t [DEPTH-1:0] tracker;
    logic [NUM_RD_PORTS-1:0]   port_stall;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        bypass_select #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .LOAD_READY (LOAD_READY),
            .RW         (RW),
            .SEL_W      (SEL_W)
        ) u_select (
            .entries    (tracker),
            .stage_data (stage_data),
            .rs         (rs[p*RW +: RW]),
            .rs_used    (rs_used[p]),
            .rf_data    (rf_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .fwd_data   (fwd_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .fwd_sel    (fwd_sel[p*SEL_W +: SEL_W]),
            .stall      (port_stall[p])
        );
    end

    assign hazard_stall = (|port_stall) && !flush;

    // A stalled issue enters as a bubble so the dependent op re-checks next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tracker <= '0;
        end else if (flush) begin
            tracker <= '0;
        end else if (advance) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                tracker[k] <= tracker[k-1];
            end
            tracker[0] <= '{valid:   issue_valid && !hazard_stall && (issue_rd != '0),
                            rd:      RD_MAX_W'(issue_rd),
                            is_load: issue_is_load};
        end
    end

`ifdef BYPASS_STATS_EN
    logic [31:0] fwd_ports;

    always_comb begin
        fwd_ports = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (fwd_sel[p*SEL_W +: SEL_W] != SEL_W'(FWD_SEL_RF)) begin
                fwd_ports = fwd_ports + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            if (hazard_stall) begin
                stall_count <= stall_count + 32'd1;
            end
            if (advance) begin
                fwd_count <= fwd_count + fwd_ports;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bypass_unit.sv
// tb/tb_bypass_unit.sv - directed and randomized checks of bypass_unit against a behavioural model
module tb_bypass_unit;

    localparam int DW = 64;
    localparam int RN = 32;
    localparam int NP = 2;
    localparam int D  = 3;
    localparam int LR = 1;
    localparam int RW = 5;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            advance;
    logic            flush;
    logic            issue_valid;
    logic [RW-1:0]   issue_rd;
    logic            issue_is_load;
    logic [D*DW-1:0] stage_data;
    logic [NP*RW-1:0] rs;
    logic [NP-1:0]   rs_used;
    logic [NP*DW-1:0] rf_data;
    logic [NP*DW-1:0] fwd_data;
    logic [NP*SW-1:0] fwd_sel;
    logic            hazard_stall;
`ifdef BYPASS_STATS_EN
    logic [31:0]     stall_count;
    logic [31:0]     fwd_count;
`endif

    always #5 clk = ~clk;

    bypass_unit #(
        .DATA_WIDTH   (DW),
        .REG_NUM      (RN),
        .NUM_RD_PORTS (NP),
        .DEPTH        (D),
        .LOAD_READY   (LR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .advance       (advance),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_is_load (issue_is_load),
        .stage_data    (stage_data),
        .rs            (rs),
        .rs_used       (rs_used),
        .rf_data       (rf_data),
        .fwd_data      (fwd_data),
        .fwd_sel       (fwd_sel),
        .hazard_stall  (hazard_stall)
`ifdef BYPASS_STATS_EN
        ,
        .stall_count   (stall_count),
        .fwd_count     (fwd_count)
`endif
    );

    // Model: list of in-flight writers, index 0 youngest
    bit          m_valid [D];
    int          m_rd    [D];
    bit          m_load  [D];
    int          exp_sel [NP];
    logic [DW-1:0] exp_data [NP];
    bit          exp_stall;
    logic [31:0] m_stall_cnt;
    logic [31:0] m_fwd_cnt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < D; k++) begin
            m_valid[k] = 1'b0;
            m_rd[k]    = 0;
            m_load[k]  = 1'b0;
        end
    endtask

    task automatic model_eval();
        int r;
        if (rst) begin
            model_clear();
            m_stall_cnt = '0;
            m_fwd_cnt   = '0;
        end
        exp_stall = 1'b0;
        for (int p = 0; p < NP; p++) begin
            exp_sel[p]  = 0;
            exp_data[p] = rf_data[p*DW +: DW];
            r = int'(rs[p*RW +: RW]);
            if (rs_used[p] && r != 0) begin
                for (int k = 0; k < D; k++) begin
                    if (m_valid[k] && m_rd[k] == r) begin
                        if (!m_load[k] || k >= LR) begin
                            exp_sel[p]  = k + 1;
                            exp_data[p] = stage_data[k*DW +: DW];
                        end else begin
                            exp_stall = 1'b1;
                        end
                        break;
                    end
                end
            end
        end
        if (flush) exp_stall = 1'b0;
    endtask

    task automatic eval();
        #2;
        model_eval();
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("fwd_sel[%0d]", p), 64'(fwd_sel[p*SW +: SW]), 64'(exp_sel[p]));
            chk($sformatf("fwd_data[%0d]", p), fwd_data[p*DW +: DW], exp_data[p]);
        end
        chk("hazard_stall", 64'(hazard_stall), 64'(exp_stall));
`ifdef BYPASS_STATS_EN
        chk("stall_count", 64'(stall_count), 64'(m_stall_cnt));
        chk("fwd_count", 64'(fwd_count), 64'(m_fwd_cnt));
`endif
    endtask

    task automatic tick();
        if (!rst) begin
            if (exp_stall) m_stall_cnt = m_stall_cnt + 32'd1;
            if (advance) begin
                for (int p = 0; p < NP; p++)
                    if (exp_sel[p] != 0) m_fwd_cnt = m_fwd_cnt + 32'd1;
            end
            if (flush) begin
                model_clear();
            end else if (advance) begin
                for (int k = D - 1; k > 0; k--) begin
                    m_valid[k] = m_valid[k-1];
                    m_rd[k]    = m_rd[k-1];
                    m_load[k]  = m_load[k-1];
                end
                m_valid[0] = issue_valid && !exp_stall && issue_rd != 0;
                m_rd[0]    = int'(issue_rd);
                m_load[0]  = issue_is_load;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; advance = 1'b1; flush = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; issue_is_load = 1'b0;
        rs = '0; rs_used = '0;
    endtask

    initial begin
        model_clear();
        m_stall_cnt = '0;
        m_fwd_cnt   = '0;
        idle();
        rst        = 1'b1;
        stage_data = {64'hC3C3, 64'hB2B2, 64'h00AA};
        rf_data    = {64'h1111, 64'h2222};

        // Reset state
        rs = {5'd3, 5'd3}; rs_used = 2'b11;
        eval();
        chk("rst_sel", 64'(fwd_sel), 64'd0);
        chk("rst_data", fwd_data[63:0], 64'h2222);
        chk("rst_stall", 64'(hazard_stall), 64'd0);
        tick();

        // ALU write x5 then dependent read forwards from EX
        idle(); issue_valid = 1'b1; issue_rd = 5'd5;
        eval(); tick();
        idle(); rs = {5'd0, 5'd5}; rs_used = 2'b01;
        eval();
        chk("alu_sel0", 64'(fwd_sel[1:0]), 64'd1);
        chk("alu_data0", fwd_data[63:0], 64'hAA);
        chk("alu_stall", 64'(hazard_stall), 64'd0);
        tick();

        // Load x7 then immediate use: one stall, then forward from stage 1
        idle(); issue_valid = 1'b1; issue_rd = 5'd7; issue_is_load = 1'b1;
        eval(); tick();
        idle(); issue_valid = 1'b1; issue_rd = 5'd9; rs = {5'd7, 5'd0}; rs_used = 2'b10;
        eval();
        chk("lu_stall", 64'(hazard_stall), 64'd1);
        chk("lu_sel1", 64'(fwd_sel[3:2]), 64'd0);
        chk("lu_data1", fwd_data[127:64], 64'h1111);
        tick();
        eval();
        chk("lu2_stall", 64'(hazard_stall), 64'd0);
        chk("lu2_sel1", 64'(fwd_sel[3:2]), 64'd2);
        chk("lu2_data1", fwd_data[127:64], 64'hB2B2);
        tick();

        // x3 in stages 0 and 2: youngest wins
        idle(); issue_valid = 1'b1; issue_rd = 5'd3;
        eval(); tick();
        idle();
        eval(); tick();
        idle(); issue_valid = 1'b1; issue_rd = 5'd3;
        eval(); tick();
        idle(); rs = {5'd0, 5'd3}; rs_used = 2'b01;
        eval();
        chk("young_sel0", 64'(fwd_sel[1:0]), 64'd1);
        chk("young_data0", fwd_data[63:0], 64'hAA);
        tick();

        // x0 is never tracked
        idle(); issue_valid = 1'b1; issue_rd = 5'd0;
        eval(); tick();
        idle(); rs_used = 2'b11;
        eval();
        chk("x0_sel", 64'(fwd_sel), 64'd0);
        chk("x0_data1", fwd_data[127:64], 64'h1111);
        chk("x0_stall", 64'(hazard_stall), 64'd0);
        tick();

        // Flush during a pending load-use hazard
        idle(); issue_valid = 1'b1; issue_rd = 5'd7; issue_is_load = 1'b1;
        eval(); tick();
        idle(); flush = 1'b1; rs = {5'd7, 5'd0}; rs_used = 2'b10;
        eval();
        chk("flush_stall", 64'(hazard_stall), 64'd0);
        tick();
        idle(); rs = {5'd7, 5'd7}; rs_used = 2'b11;
        eval();
        chk("post_flush_sel", 64'(fwd_sel), 64'd0);
        tick();

        // Reset mid-stream reverts immediately
        idle(); issue_valid = 1'b1; issue_rd = 5'd5;
        eval(); tick();
        idle(); rs = {5'd0, 5'd5}; rs_used = 2'b01;
        eval();
        chk("pre_rst_sel0", 64'(fwd_sel[1:0]), 64'd1);
        rst = 1'b1;
        eval();
        chk("mid_rst_sel", 64'(fwd_sel), 64'd0);
        chk("mid_rst_data0", fwd_data[63:0], 64'h2222);
`ifdef BYPASS_STATS_EN
        chk("mid_rst_stall_count", 64'(stall_count), 64'd0);
        chk("mid_rst_fwd_count", 64'(fwd_count), 64'd0);
`endif
        tick();

        // Randomized traffic over a small register window to provoke hits
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 99) == 0);
            advance       = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 15) == 0);
            issue_valid   = 1'($urandom_range(0, 1));
            issue_rd      = RW'($urandom_range(0, 7));
            issue_is_load = ($urandom_range(0, 2) == 0);
            rs_used       = NP'($urandom_range(0, 3));
            for (int p = 0; p < NP; p++) begin
                rs[p*RW +: RW]      = RW'($urandom_range(0, 7));
                rf_data[p*DW +: DW] = {$urandom, $urandom};
            end
            for (int k = 0; k < D; k++)
                stage_data[k*DW +: DW] = {$urandom, $urandom};
            eval();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bypass_unit.md
# bypass_unit

Parametrised forwarding and hazard unit sitting between decode and the execute/memory pipeline. It tracks in-flight register writes across `DEPTH` downstream stages in an internal register tracker. For each of `NUM_RD_PORTS` source operands it selects the youngest ready producer, or falls back to the register file. It also raises a load-use stall when the youngest matching producer's data is not yet available.

## Interface
- `DATA_WIDTH`, 64, operand/result width
- `REG_NUM`, 32, architectural registers; `RW = $clog2(REG_NUM)`
- `NUM_RD_PORTS`, 2, source operands checked per cycle
- `DEPTH`, 3, tracked stages after decode; index 0 = EX (youngest)
- `LOAD_READY`, 1, first stage index at which load data is valid
- `clk` in 1, clock
- `rst` in 1, one clock; reset is asynchronous and active-high
- `advance` in 1, pipeline moves one stage this cycle
- `flush` in 1, kill all tracked entries
- `issue_valid` in 1, instruction leaving decode writes a register
- `issue_rd` in RW, its destination
- `issue_is_load` in 1, its result comes from memory
- `stage_data` in DEPTH*DATA_WIDTH, current result of each tracked stage
- `rs` in NUM_RD_PORTS*RW, source register per port
- `rs_used` in NUM_RD_PORTS, port actually reads `rs`
- `rf_data` in NUM_RD_PORTS*DATA_WIDTH, register-file read data
- `fwd_data` out NUM_RD_PORTS*DATA_WIDTH, selected operand
- `fwd_sel` out NUM_RD_PORTS*$clog2(DEPTH+1), 0 = register file, k+1 = stage k
- `hazard_stall` out 1, decode must hold

## Operation
- Tracker holds `DEPTH` entries {valid, rd, is_load}.
- On `advance`, entries shift: entry k goes to k+1, and entry DEPTH-1 is dropped.
- Entry 0 loads {`issue_valid && !hazard_stall && issue_rd!=0`, `issue_rd`, `issue_is_load`}, so a stall inserts a bubble.
- Without `advance`, the tracker holds.
- `flush` clears all valid bits. If `flush` and `advance` are both high, `flush` wins and entry 0 is also invalid.
- Match for a port: `rs_used`, `rs != 0`, and entry valid with `rd == rs`.
- Selection priority is youngest first (lowest k). Only the youngest match is considered, even when it is not ready.
- Entry k is ready if `!is_load || k >= LOAD_READY`.
- Youngest match ready: `fwd_sel = k+1`, `fwd_data = stage_data[k]`.
- Youngest match not ready: `hazard_stall = 1`, `fwd_sel = 0`, `fwd_data = rf_data`.
- No match: `fwd_sel = 0`, `fwd_data = rf_data`.
- `hazard_stall` is the OR over all ports. It is forced to 0 while `flush` is high.
- Register x0 is never tracked and never forwarded.

## Timing
- Tracker is registered and updated on the rising edge of `clk`.
- `fwd_data`, `fwd_sel` and `hazard_stall` are combinational from the tracker plus the current inputs, with zero latency.
- Reset clears all tracker entries immediately, asynchronously. While reset is held: `hazard_stall = 0`, `fwd_sel = 0`, `fwd_data = rf_data`.
- Reset mid-operation discards all in-flight entries. No recovery state is kept.
- Issue in cycle n becomes visible as entry 0 in cycle n+1 (when `advance` is high).
- With `DEPTH=3` and `LOAD_READY=1`, a load followed immediately by a dependent instruction costs exactly one stall cycle.

## Configuration
- `BYPASS_STATS_EN` defined: adds outputs `stall_count` (32) and `fwd_count` (32).
  - `stall_count` increments on each cycle with `hazard_stall` high.
  - `fwd_count` increments by the number of ports with `fwd_sel != 0` on each `advance` cycle.
  - Both counters wrap at 2^32 and reset to 0.
- `BYPASS_STATS_EN` undefined: the ports and counters are absent, and the remaining behaviour is identical.

## Structure
- `bypass_pkg` holds:
  - the tracker entry struct `bypass_entry_t`
  - the `FWD_SEL_RF` = 0 constant
  - a function converting stage index to `fwd_sel`
- Sub-module `bypass_select` implements the per-port priority match, ready check and data select. It is instantiated `NUM_RD_PORTS` times via generate.
- The tracker shift register, stall OR and stats counters live in `bypass_unit`.

## Test plan
- ALU write x5 issued, dependent `rs[0]=5` next cycle, `stage_data[0]=0xAA` -> `fwd_sel[0]=1`, `fwd_data[0]=0xAA`, no stall.
- Load to x7, then `rs[1]=7` next cycle -> `hazard_stall=1` for one cycle. The following cycle gives `fwd_sel[1]=2` with `stage_data[1]`.
- x3 in both stage 0 and stage 2, `rs[0]=3` -> stage 0 wins, `fwd_sel[0]=1`.
- `rs=0` with an x0 write issued -> `fwd_sel=0`, `fwd_data=rf_data`, no stall.
- `flush` while a load-use hazard is pending -> `hazard_stall=0`, and all ports select the register file the next cycle.
- Assert `rst` mid-stream with a valid tracker -> outputs revert to register file immediately. With `BYPASS_STATS_EN`, counters read 0.
